// File: rtl/instruction_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit.
//   ifu_state_t : fetch FSM states (request, hold, drop-outstanding)
//   NOP_WORD    : word presented when no valid instruction is buffered
//   PC_STEP     : sequential PC increment
//   word_align  : clears the byte-offset bits of an address
package instruction_fetch_unit_pkg;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_HOLD = 2'd1,
        S_DROP = 2'd2
    } ifu_state_t;

    localparam logic [31:0] NOP_WORD = '0;
    localparam logic [31:0] PC_STEP  = 32'd4;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/instruction_fetch_unit_instr_buffer.sv
// One-entry fetch buffer holding an instruction word, its PC and a
// branch-delay-slot marker.
//   clock, reset         : rising-edge clock, asynchronous active-low reset
//   load, load_*         : capture a new entry (wins over consume)
//   consume              : presented entry taken by the IF/ID register
//   invalidate           : drop the entry (wins over everything)
//   mark_delay           : OR the delay marker into an entry that is held
//   buf_valid/word/pc/delay : current entry
module ifu_instr_buffer
    import instruction_fetch_unit_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        load,
    input  logic [31:0] load_word,
    input  logic [31:0] load_pc,
    input  logic        load_delay,
    input  logic        consume,
    input  logic        invalidate,
    input  logic        mark_delay,
    output logic        buf_valid,
    output logic [31:0] buf_word,
    output logic [31:0] buf_pc,
    output logic        buf_delay
);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            buf_valid <= 1'b0;
            buf_word  <= NOP_WORD;
            buf_pc    <= '0;
            buf_delay <= 1'b0;
        end else if (invalidate) begin
            buf_valid <= 1'b0;
            buf_delay <= 1'b0;
        end else if (load) begin
            buf_valid <= 1'b1;
            buf_word  <= load_word;
            buf_pc    <= load_pc;
            buf_delay <= load_delay;
        end else if (consume) begin
            buf_valid <= 1'b0;
            buf_delay <= 1'b0;
        end else if (buf_valid) begin
            buf_delay <= buf_delay | mark_delay;
        end
    end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the PC, runs the imem request/ready handshake and keeps
// a one-entry word buffer feeding the IF/ID pipeline register.
//   clock, reset          : rising-edge clock, asynchronous active-low reset
//   id_stall              : IF/ID holding, presented word not consumed
//   if_flush              : kill buffer and outstanding fetch, restart at EXC_VECTOR
//   id_is_branch          : ID holds a branch; next consumed word is its delay slot
//   id_redirect/_target   : taken branch/jump resolved in ID
//   imem_req/addr/ready/rdata : instruction memory handshake
//   if_instruction, if_pc_add_4, if_pc_usable, if_stall, if_bra_delay : IF/ID inputs
//   if_addr_error         : misaligned redirect target trapped
// Build option: IFU_MISALIGN_TRAP_EN traps misaligned redirect targets;
// without it the low two target bits are cleared and if_addr_error is 0.
module instruction_fetch_unit
    import instruction_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [31:0] EXC_VECTOR = 32'h0000_0080
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        id_stall,
    input  logic        if_flush,
    input  logic        id_is_branch,
    input  logic        id_redirect,
    input  logic [31:0] id_redirect_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] if_instruction,
    output logic [31:0] if_pc_add_4,
    output logic [31:0] if_pc_usable,
    output logic        if_stall,
    output logic        if_bra_delay,
    output logic        if_addr_error
);

    ifu_state_t  state, state_n;
    logic [31:0] pc, pc_n;
    logic [31:0] drop_addr, drop_addr_n;  // address of the response being dropped
    logic        req_on;                  // first request goes out one cycle after reset
    logic        trap, trap_n;

    logic        buf_valid, buf_delay;
    logic [31:0] buf_word, buf_pc;
    logic        buf_load, buf_inval, load_delay;
    logic [31:0] load_word, load_pc;

    logic        consume, redirect, resp, pending, misalign;
    logic [31:0] redirect_pc;

`ifdef IFU_MISALIGN_TRAP_EN
    assign misalign    = |id_redirect_target[1:0];
    assign redirect_pc = id_redirect_target;
`else
    assign misalign    = 1'b0;
    assign redirect_pc = word_align(id_redirect_target);
`endif

    // S_DROP keeps requesting the old address so a handshake is never altered.
    assign imem_req  = req_on && ((state == S_DROP) || ((state == S_REQ) && !trap));
    assign imem_addr = (state == S_DROP) ? drop_addr : pc;

    // A trapped entry stays presented until a flush.
    assign consume  = buf_valid && !id_stall && !trap;
    assign redirect = id_redirect && !id_stall && !trap;
    assign resp     = imem_req && imem_ready;
    assign pending  = imem_req && !imem_ready;

    always_comb begin
        state_n     = state;
        pc_n        = pc;
        drop_addr_n = drop_addr;
        trap_n      = trap;
        buf_load    = 1'b0;
        buf_inval   = 1'b0;
        load_word   = imem_rdata;
        load_pc     = pc;
        // An empty buffer while ID holds a branch means this capture is its delay slot.
        load_delay  = id_is_branch && !buf_valid;

        if (if_flush) begin
            buf_inval = 1'b1;
            pc_n      = EXC_VECTOR;
            trap_n    = 1'b0;
            state_n   = pending ? S_DROP : S_REQ;
            if (pending) begin
                drop_addr_n = imem_addr;
            end
        end else if (redirect) begin
            // Any response arriving now is the sequential fetch and is discarded.
            pc_n    = redirect_pc;
            state_n = pending ? S_DROP : S_REQ;
            if (pending) begin
                drop_addr_n = imem_addr;
            end
            if (misalign) begin
                trap_n     = 1'b1;
                buf_load   = 1'b1;
                load_word  = NOP_WORD;
                load_pc    = redirect_pc;
                load_delay = 1'b0;
            end
        end else begin
            unique case (state)
                S_REQ: begin
                    if (resp) begin
                        if (!buf_valid || consume) begin
                            buf_load = 1'b1;
                            pc_n     = pc + PC_STEP;
                        end else begin
                            state_n = S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (consume) begin
                        state_n = S_REQ;
                    end
                end
                S_DROP: begin
                    if (imem_ready) begin
                        state_n = S_REQ;
                    end
                end
                default: state_n = S_REQ;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= S_REQ;
            pc        <= RESET_PC;
            drop_addr <= '0;
            req_on    <= 1'b0;
            trap      <= 1'b0;
        end else begin
            state     <= state_n;
            pc        <= pc_n;
            drop_addr <= drop_addr_n;
            req_on    <= 1'b1;
            trap      <= trap_n;
        end
    end

    ifu_instr_buffer u_buffer (
        .clock      (clock),
        .reset      (reset),
        .load       (buf_load),
        .load_word  (load_word),
        .load_pc    (load_pc),
        .load_delay (load_delay),
        .consume    (consume),
        .invalidate (buf_inval),
        .mark_delay (id_is_branch),
        .buf_valid  (buf_valid),
        .buf_word   (buf_word),
        .buf_pc     (buf_pc),
        .buf_delay  (buf_delay)
    );

    assign if_stall       = !buf_valid;
    assign if_instruction = buf_valid ? buf_word : NOP_WORD;
    assign if_pc_usable   = buf_valid ? buf_pc : '0;
    assign if_pc_add_4    = buf_valid ? (buf_pc + PC_STEP) : '0;
    assign if_bra_delay   = buf_valid && !trap && (buf_delay || id_is_branch);

`ifdef IFU_MISALIGN_TRAP_EN
    assign if_addr_error = trap;
`else
    assign if_addr_error = 1'b0;
`endif

endmodule
